// File: rtl/cpu_mul_pkg.sv
// Shared types for the execute-stage multiply pipeline: operation encoding,
// per-stage control record and the supported depth limit.
package cpu_mul_pkg;

  localparam int MUL_MAX_STAGES = 8;

  typedef enum logic [1:0] {
    MUL    = 2'd0,
    MULH   = 2'd1,
    MULHSU = 2'd2,
    MULHU  = 2'd3
  } mul_op_t;

  // Operand and register widths are module parameters, so rd_id and data
  // travel in parallel arrays beside this record.
  typedef struct packed {
    logic    valid;
    mul_op_t op;
    logic    wb_en;
  } mul_stage_t;

endpackage

// File: rtl/cpu_mul_core.sv
// Combinational signed/unsigned multiplier with result word select; feeds
// stage 0 of the pipeline so later stages act as retiming registers.
module cpu_mul_core
  import cpu_mul_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  mul_op_t           i_op,
  input  logic [XLEN-1:0]   i_a,
  input  logic [XLEN-1:0]   i_b,
  output logic [XLEN-1:0]   o_result
);

  logic              w_signA;
  logic              w_signB;
  logic [2*XLEN-1:0] w_aWide;
  logic [2*XLEN-1:0] w_bWide;
  logic [2*XLEN-1:0] w_prod;

  assign w_signA = ((i_op == MULH) || (i_op == MULHSU)) & i_a[XLEN-1];
  assign w_signB = (i_op == MULH) & i_b[XLEN-1];

  // Extending both operands to the full product width makes a plain
  // modular multiply produce the correct signed/unsigned 2*XLEN result.
  assign w_aWide = {{XLEN{w_signA}}, i_a};
  assign w_bWide = {{XLEN{w_signB}}, i_b};
  assign w_prod  = w_aWide * w_bWide;

  assign o_result = (i_op == MUL) ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN];

endmodule

// File: rtl/cpu_mul_pipe.sv
// Fully pipelined integer multiply unit with stall/flush control and a
// per-register busy mask for the hazard unit.
module cpu_mul_pipe
  import cpu_mul_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int REG_ID_W = 5,
  parameter int STAGES   = 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  input  logic [1:0]             in_op,
  input  logic [REG_ID_W-1:0]    in_rd_id,
  input  logic [XLEN-1:0]        in_ra_data,
  input  logic [XLEN-1:0]        in_rb_data,
  input  logic                   in_wb_en,
  input  logic                   stall,
  input  logic                   flush,
  output logic                   out_valid,
  output logic [REG_ID_W-1:0]    out_rd_id,
  output logic [XLEN-1:0]        out_data,
  output logic                   out_wb_en,
  output logic [2**REG_ID_W-1:0] busy_mask,
  output logic [3:0]             in_flight
);

  localparam int DEPTH = (STAGES < 1) ? 1 :
                         ((STAGES > MUL_MAX_STAGES) ? MUL_MAX_STAGES : STAGES);

  mul_stage_t             r_ctl  [DEPTH];
  logic [REG_ID_W-1:0]    r_rd   [DEPTH];
  logic [XLEN-1:0]        r_data [DEPTH];

  logic [XLEN-1:0]        w_result;
  logic                   w_accept;
  logic [2**REG_ID_W-1:0] w_busy;
  logic [3:0]             w_count;

  cpu_mul_core #(
    .XLEN(XLEN)
  ) u_core (
    .i_op    (mul_op_t'(in_op)),
    .i_a     (in_ra_data),
    .i_b     (in_rb_data),
    .o_result(w_result)
  );

  assign w_accept = in_valid & ~stall & ~flush;

  // Empty stages are zeroed so idle outputs read as 0; flush wins over stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_ctl[i]  <= '0;
        r_rd[i]   <= '0;
        r_data[i] <= '0;
      end
    end else if (flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_ctl[i]  <= '0;
        r_rd[i]   <= '0;
        r_data[i] <= '0;
      end
    end else if (!stall) begin
      if (w_accept) begin
        r_ctl[0]  <= '{valid: 1'b1, op: mul_op_t'(in_op), wb_en: in_wb_en};
        r_rd[0]   <= in_rd_id;
        r_data[0] <= w_result;
      end else begin
        r_ctl[0]  <= '0;
        r_rd[0]   <= '0;
        r_data[0] <= '0;
      end
      for (int i = 1; i < DEPTH; i++) begin
        r_ctl[i]  <= r_ctl[i-1];
        r_rd[i]   <= r_rd[i-1];
        r_data[i] <= r_data[i-1];
      end
    end
  end

  always_comb begin
    w_busy  = '0;
    w_count = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (r_ctl[i].valid) begin
        w_count = w_count + 4'd1;
        if (r_ctl[i].wb_en) begin
          w_busy[r_rd[i]] = 1'b1;
        end
      end
    end
    // Register 0 is hardwired, so it never needs interlocking.
    w_busy[0] = 1'b0;
  end

  assign out_valid = r_ctl[DEPTH-1].valid;
  assign out_rd_id = r_rd[DEPTH-1];
  assign out_data  = r_data[DEPTH-1];
  assign out_wb_en = r_ctl[DEPTH-1].valid & r_ctl[DEPTH-1].wb_en & (r_rd[DEPTH-1] != '0);
  assign busy_mask = w_busy;
  assign in_flight = w_count;

endmodule

// File: doc/cpu_mul_pipe.md
# cpu_mul_pipe

Parametrised, fully pipelined integer multiply unit for the CPU execute stage. It accepts one multiply per cycle with destination register id, operands, operation mode and writeback enable. It delivers the selected result word after a fixed, configurable number of stages. It also exports a per-register busy mask to the hazard unit, and honours pipeline stall and flush.

## Interface
Parameters:
- `XLEN`, 32, operand and result width.
- `REG_ID_W`, 5, destination register id width.
- `STAGES`, 3, pipeline depth; legal values are 1 to 8.

Ports:
- `clk`  in  1  single clock for the block.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  operation presented this cycle.
- `in_op`  in  2  operation mode: MUL (low word), MULH (signed×signed, high word), MULHSU (signed×unsigned, high word), MULHU (unsigned×unsigned, high word).
- `in_rd_id`  in  REG_ID_W  destination register.
- `in_ra_data`, `in_rb_data`  in  XLEN  operands a and b.
- `in_wb_en`  in  1  writeback enable for the operation, from decode.
- `stall`  in  1  freeze the whole pipeline.
- `flush`  in  1  kill every operation in flight.
- `out_valid`  out  1  result present.
- `out_rd_id`  out  REG_ID_W  destination of the result.
- `out_data`  out  XLEN  result word.
- `out_wb_en`  out  1  writeback request; forced to 0 when `out_rd_id`==0.
- `busy_mask`  out  2^REG_ID_W  bit r set while an op with rd=r and wb_en=1 is in flight.
- `in_flight`  out  4  count of valid stages.

## Operation
- **Accept.** An operation is accepted at a rising edge when `in_valid`=1, `stall`=0 and `flush`=0. If `in_valid`=1 while stall or flush is asserted, the operation is dropped. Upstream must hold it.
- **Product.** Each stage carries valid, op, rd_id, wb_en and data.
- Operands are extended to XLEN+1 bits according to op: a is sign-extended for MULH and MULHSU, b is sign-extended for MULH only. The full 2·XLEN product is formed.
- MUL returns bits [XLEN-1:0]. All other modes return bits [2·XLEN-1:XLEN].
- **Stall.** When `stall`=1, every stage register, including the output stage, holds its value. Outputs remain constant.
- **Flush.** `flush`=1 clears every valid bit at the next edge and discards any input in the same cycle. Flush has priority over stall.
- **Busy mask.** `busy_mask` is the combinational OR over all valid stages with wb_en=1 of onehot(rd_id), including the output stage. Bit 0 is never set.
- **In-flight count.** `in_flight` is the population count of the valid bits.
- **Ordering.** Results leave in strict issue order. There is no reordering and no backpressure other than `stall`.

## Timing
- **Reset.** During reset and after reset release, every valid bit is 0. `out_valid`=0, `out_rd_id`=0, `out_data`=0, `out_wb_en`=0, `busy_mask`=0, `in_flight`=0. Reset asserted mid-operation discards everything immediately, asynchronously.
- **Latency.** An op accepted at edge k has `out_valid`=1 in the cycle following edge k+STAGES−1, assuming no stall. With STAGES=1, the result appears right after the accept edge.
- **Stall timing.** Each stalled cycle adds exactly one cycle of latency to every op in flight.
- **Result duration.** Each op produces exactly one `out_valid` cycle, plus any cycles held by stall.
- **Throughput.** One op per cycle. Back-to-back accepts give consecutive `out_valid` cycles.
- **Busy mask timing.** A `busy_mask` bit rises in the cycle after accept and falls in the cycle after the op leaves the output stage. Two in-flight ops to the same rd keep the bit set until the later one leaves.

## Structure
- **Package `cpu_mul_pkg`:**
  - `mul_op_t` enum: MUL=0, MULH=1, MULHSU=2, MULHU=3.
  - Stage struct `mul_stage_t`.
  - `MUL_MAX_STAGES`=8.
- **Sub-module `cpu_mul_core`:**
  - Combinational signed/unsigned (XLEN+1)×(XLEN+1) product and word select.
  - Placed before stage 0, so the remaining stages are retiming registers.
- **Top level:** holds the stage array, the stall/flush control, and the busy-mask and count reductions.

## Test plan
Configuration XLEN=32, STAGES=3 unless stated.
1. **MUL, single op.** MUL a=7, b=0xFFFFFFFD, rd=5, wb_en=1 → `out_data`=0xFFFFFFEB, `out_rd_id`=5, `out_valid` exactly 3 edges after accept. `busy_mask`[5]=1 during flight.
2. **High-word modes.** a=b=0x80000000 → MULH gives 0x40000000 and MULHU gives 0x40000000. a=b=0xFFFFFFFF → MULHSU gives 0xFFFFFFFF and MULHU gives 0xFFFFFFFE. MUL with a=b=0xFFFFFFFF gives 0x00000001.
3. **Back-to-back.** Four back-to-back ops to rd 1..4 → four consecutive `out_valid` cycles in order. `in_flight` peaks at 3.
4. **Stall.** `stall` for 2 cycles with 2 ops in flight → both latencies become 5. Outputs are held unchanged while stalled. An `in_valid` presented during the stall is not accepted.
5. **Flush and rd 0.**
   - `flush` with 3 ops in flight plus a concurrent input → no `out_valid` afterwards. `busy_mask`=0 and `in_flight`=0 in the next cycle.
   - An op to rd 0 → `out_valid`=1, `out_wb_en`=0.
6. **Reset mid-operation.** Drop `rst_n` asynchronously mid-flight → all outputs go to 0 before the next edge. No stale result appears after release.
